// File: rtl/scan_ram_if.sv
// Scan RAM second-port (s2) write bus.
// Master drives the RAM; slave is the RAM side.
interface scan_ram_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] address2;
  logic [31:0]       writedata2;
  logic [3:0]        byteenable2;
  logic              chipselect2;
  logic              write2;
  logic              clken2;

  modport master (
    output address2,
    output writedata2,
    output byteenable2,
    output chipselect2,
    output write2,
    output clken2
  );

  modport slave (
    input address2,
    input writedata2,
    input byteenable2,
    input chipselect2,
    input write2,
    input clken2
  );
endinterface

// File: rtl/scan_ram_writer.sv
// Barcode capture engine: sensor runs -> run-length
// words written into the scan RAM through port s2.
module scan_ram_writer #(
  parameter int DEPTH       = 100,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT     = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sensor_in,
  input  logic              start,
  input  logic              abort,
  scan_ram_if.master        ram,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              timed_out
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [29:0] RUN_MAX = '1;
  localparam logic [29:0] TO_CNT = 30'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [SS-1:0] sync_q;
  logic          s;
  logic          s_prev;
  logic          run_edge;
  logic [29:0]   run_cnt;

  logic wr_en;
  logic wr_to;
  logic clr;
  logic set_done;

  assign s        = sync_q[SS-1];
  assign run_edge = s != s_prev;
  assign busy     = (state == S_ARM) || (state == S_CAPTURE);

  assign ram.byteenable2 = 4'hF;
  assign ram.clken2      = 1'b1;

  // Synchronize the asynchronous sensor bit and keep its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SS-2:0], sensor_in};
      s_prev <= s;
    end
  end

  // Length of the current run; restarts at 1 on each level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (run_edge) begin
      run_cnt <= 30'd1;
    end else if (run_cnt != RUN_MAX) begin
      run_cnt <= run_cnt + 30'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and write decisions; abort beats edge and timeout.
  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    wr_to    = 1'b0;
    clr      = 1'b0;
    set_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ARM;
          clr     = 1'b1;
        end
      end
      S_ARM: begin
        if (abort)         state_n = S_IDLE;
        else if (run_edge) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (run_edge) begin
          wr_en = 1'b1;
          if (word_count == LAST) begin
            state_n  = S_DONE;
            set_done = 1'b1;
          end
        end else if (run_cnt == TO_CNT) begin
          wr_en    = 1'b1;
          wr_to    = 1'b1;
          state_n  = S_DONE;
          set_done = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_n = S_ARM;
          clr     = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered RAM write port and scan status.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram.write2      <= 1'b0;
      ram.chipselect2 <= 1'b0;
      ram.address2    <= '0;
      ram.writedata2  <= '0;
      word_count      <= '0;
      done            <= 1'b0;
      timed_out       <= 1'b0;
    end else begin
      ram.write2      <= wr_en;
      ram.chipselect2 <= wr_en;
      if (wr_en) begin
        ram.address2   <= word_count;
        ram.writedata2 <= {s_prev, wr_to, run_cnt};
        word_count     <= word_count + ONE;
      end
      if (clr) begin
        word_count <= '0;
        done       <= 1'b0;
        timed_out  <= 1'b0;
      end
      if (set_done) begin
        done      <= 1'b1;
        timed_out <= wr_to;
      end
    end
  end

endmodule
